// File: rtl/issue_queue_pkg.sv
// Shared constants for the issue queue: data widths, unit codes and FSM states.
package issue_queue_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned REG_SIZE  = 6;

  localparam logic [2:0] UNIT_LW   = 3'b000;
  localparam logic [2:0] UNIT_SW   = 3'b001;
  localparam logic [2:0] UNIT_ADD  = 3'b010;
  localparam logic [2:0] UNIT_MUL  = 3'b011;
  localparam logic [2:0] UNIT_MV   = 3'b100;
  localparam logic [2:0] UNIT_HALT = 3'b101;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } iq_state_e;

endpackage

// File: rtl/iq_storage.sv
// Entry storage for the issue queue: synchronous write port, asynchronous head read port.
module iq_storage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Cleared on reset so the head fields read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/issue_queue.sv
// In-order decoded-instruction buffer between fetch and the reservation station.
// Optional same-cycle fetch-to-RS bypass when ISSUE_BYPASS_EN is defined.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned UNIT_W = 3,
  parameter int unsigned REG_W  = REG_SIZE,
  parameter int unsigned WORD_W = WORD_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [UNIT_W-1:0]          in_unit,
  input  logic [REG_W-1:0]           in_reg1,
  input  logic [REG_W-1:0]           in_reg2,
  input  logic [REG_W-1:0]           in_reg3,
  input  logic                       in_hasimm,
  input  logic [WORD_W-1:0]          in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [UNIT_W-1:0]          out_unit,
  output logic [REG_W-1:0]           out_reg1,
  output logic [REG_W-1:0]           out_reg2,
  output logic [REG_W-1:0]           out_reg3,
  output logic                       out_hasimm,
  output logic [WORD_W-1:0]          out_imm,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = UNIT_W + 3 * REG_W + 1 + WORD_W;

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  iq_state_e       state_q, state_d;

  logic [EntW-1:0]   wdata, rdata;
  logic [UNIT_W-1:0] head_unit;
  logic [REG_W-1:0]  head_reg1, head_reg2, head_reg3;
  logic              head_hasimm;
  logic [WORD_W-1:0] head_imm;
  logic              empty, full, head_halt, bypass, enq, pop;

  assign wdata = {in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm};
  assign {head_unit, head_reg1, head_reg2, head_reg3, head_hasimm, head_imm} = rdata;

  iq_storage #(
    .DEPTH(DEPTH),
    .WIDTH(EntW)
  ) u_storage (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (enq),
    .waddr_i(tail_q),
    .wdata_i(wdata),
    .raddr_i(head_q),
    .rdata_o(rdata)
  );

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CntW'(DEPTH));
    head_halt = !empty && (head_unit == UNIT_W'(UNIT_HALT));
    in_ready  = !full && (state_q == StRun);
`ifdef ISSUE_BYPASS_EN
    bypass = empty && !flush && in_valid && (in_unit != UNIT_W'(UNIT_HALT)) &&
             (state_q == StRun);
`else
    bypass = 1'b0;
`endif
    out_valid = (!empty && !head_halt) || bypass;
    if (bypass) begin
      {out_unit, out_reg1, out_reg2, out_reg3, out_hasimm, out_imm} = wdata;
    end else begin
      {out_unit, out_reg1, out_reg2, out_reg3, out_hasimm, out_imm} = rdata;
    end
    // A bypassed op that the RS takes this cycle never touches storage.
    enq = in_valid && in_ready && !flush && !(bypass && out_ready);
    // A halt at the head is retired internally without ever being offered.
    pop = !empty && !flush && (head_halt || out_ready);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    unique case (state_q)
      StRun, StDrain: begin
        if (flush) begin
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
          state_d = StRun;
        end else begin
          if (pop) head_d = head_q + 1'b1;
          if (enq) tail_d = tail_q + 1'b1;
          count_d = count_q + CntW'(enq) - CntW'(pop);
          if (enq && (in_unit == UNIT_W'(UNIT_HALT))) state_d = StDrain;
          if (pop && head_halt) state_d = StHalted;
        end
      end
      default: state_d = StHalted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= StRun;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count  = count_q;
  assign halted = (state_q == StHalted);

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: queue-based reference model plus directed literal checks.
module tb_issue_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  u;
    logic [5:0]  r1, r2, r3;
    logic        h;
    logic [31:0] imm;
  } ent_t;

  logic        clk, rst_n, flush, in_valid, in_ready, in_hasimm, out_valid, out_ready;
  logic        out_hasimm, halted;
  logic [2:0]  in_unit, out_unit;
  logic [5:0]  in_reg1, in_reg2, in_reg3, out_reg1, out_reg2, out_reg3;
  logic [31:0] in_imm, out_imm;
  logic [2:0]  count;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_unit   (in_unit),
    .in_reg1   (in_reg1),
    .in_reg2   (in_reg2),
    .in_reg3   (in_reg3),
    .in_hasimm (in_hasimm),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_unit  (out_unit),
    .out_reg1  (out_reg1),
    .out_reg2  (out_reg2),
    .out_reg3  (out_reg3),
    .out_hasimm(out_hasimm),
    .out_imm   (out_imm),
    .count     (count),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain FIFO of entries plus a run/drain/halted mode.
  ent_t q[$];
  int   mst;  // 0 run, 1 drain, 2 halted

  logic last_ov, last_ir;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
`ifdef ISSUE_BYPASS_EN
    return (q.size() == 0) && !flush && in_valid && (in_unit != 3'd5) && (mst == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_outputs();
    bit   byp, ov;
    ent_t e;
    byp = model_bypass();
    ov  = ((q.size() > 0) && (q[0].u != 3'd5)) || byp;
    chk("in_ready", in_ready, (mst == 0) && (q.size() < DEPTH));
    chk("out_valid", out_valid, ov);
    chk("count", count, q.size());
    chk("halted", halted, mst == 2);
    if (ov) begin
      if (byp) e = '{in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm};
      else     e = q[0];
      chk("out_unit", out_unit, e.u);
      chk("out_reg1", out_reg1, e.r1);
      chk("out_reg2", out_reg2, e.r2);
      chk("out_reg3", out_reg3, e.r3);
      chk("out_hasimm", out_hasimm, e.h);
      chk("out_imm", out_imm, e.imm);
    end
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; out_ready = 0;
    in_unit = 0; in_reg1 = 0; in_reg2 = 0; in_reg3 = 0; in_hasimm = 0; in_imm = 0;
  endtask

  // One cycle: drive at negedge, check before the edge, advance the model at the edge.
  task automatic step(input bit v, input ent_t e, input bit ordy, input bit fl);
    bit   byp, acc, pop;
    ent_t popped;
    @(negedge clk);
    in_valid = v; flush = fl; out_ready = ordy;
    in_unit = e.u; in_reg1 = e.r1; in_reg2 = e.r2; in_reg3 = e.r3;
    in_hasimm = e.h; in_imm = e.imm;
    #1;
    compare_outputs();
    last_ov = out_valid;
    last_ir = in_ready;
    byp = model_bypass();
    acc = v && (mst == 0) && (q.size() < DEPTH) && !(byp && ordy);
    pop = (q.size() > 0) && ((q[0].u == 3'd5) || ordy);
    @(posedge clk);
    if (mst != 2) begin
      if (fl) begin
        q.delete();
        mst = 0;
      end else begin
        if (pop) begin
          popped = q.pop_front();
          if (popped.u == 3'd5) mst = 2;
        end
        if (acc) begin
          q.push_back(e);
          if (e.u == 3'd5) mst = 1;
        end
      end
    end
    #1 set_idle();
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_halted", halted, 0);
    q.delete();
    mst = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic ent_t mk(input logic [2:0] u, input logic [5:0] r1, input logic [5:0] r2,
                              input logic [5:0] r3, input logic h, input logic [31:0] imm);
    ent_t e;
    e.u = u; e.r1 = r1; e.r2 = r2; e.r3 = r3; e.h = h; e.imm = imm;
    return e;
  endfunction

  function automatic ent_t rnd_ent(input bit allow_halt);
    ent_t e;
    e.u = 3'($urandom_range(0, 4));
    if (allow_halt && ($urandom_range(0, 29) == 0)) e.u = 3'd5;
    e.r1 = 6'($urandom); e.r2 = 6'($urandom); e.r3 = 6'($urandom);
    e.h = 1'($urandom); e.imm = $urandom;
    return e;
  endfunction

  ent_t nop;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0);
    rst_n = 0;
    set_idle();
    q.delete();
    mst = 0;
    #12;
    chk("init_in_ready", in_ready, 1);
    chk("init_out_valid", out_valid, 0);
    chk("init_count", count, 0);
    chk("init_halted", halted, 0);
    chk("init_out_unit", out_unit, 0);
    chk("init_out_imm", out_imm, 0);
    @(negedge clk);
    rst_n = 1;

    // Single add with RS ready: latency 1 without bypass, 0 with it.
    step(1, mk(3'd2, 6'd2, 6'd3, 6'd0, 1'b1, 32'd5), 1, 0);
`ifdef ISSUE_BYPASS_EN
    chk("lat_same_cycle_ov", last_ov, 1);
    chk("lat_count", count, 0);
    chk("lat_ov_after", out_valid, 0);
`else
    chk("lat_same_cycle_ov", last_ov, 0);
    chk("lat_ov_after", out_valid, 1);
    chk("lat_unit", out_unit, 3'd2);
    chk("lat_reg1", out_reg1, 6'd2);
    chk("lat_reg2", out_reg2, 6'd3);
    chk("lat_imm", out_imm, 32'd5);
    chk("lat_hasimm", out_hasimm, 1);
    step(0, nop, 1, 0);
    chk("lat_count_drained", count, 0);
`endif

    // Back-pressure: five pushes, four stick, then pop in order with a stall in between.
    for (int i = 0; i < 5; i++) step(1, mk(3'd3, 6'(10 + i), 6'd1, 6'd2, 1'b0, 32'(i)), 0, 0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pop_order_reg1", out_reg1, 6'(10 + i));
      step(0, nop, 0, 0);
      chk("stall_reg1", out_reg1, 6'(10 + i));
      step(0, nop, 1, 0);
    end
    chk("drained_count", count, 0);

    // Flush with a simultaneous push.
    for (int i = 0; i < 3; i++) step(1, rnd_ent(0), 0, 0);
    step(1, mk(3'd1, 6'd7, 6'd7, 6'd7, 1'b0, 32'd9), 0, 1);
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    step(0, nop, 1, 0);
    chk("flush_not_stored", out_valid, 0);

    // mv, halt, add: add is refused and the halt never surfaces.
    step(1, mk(3'd4, 6'd4, 6'd5, 6'd6, 1'b0, 32'd0), 1, 0);
    step(1, mk(3'd5, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0), 1, 0);
    step(1, mk(3'd2, 6'd1, 6'd1, 6'd1, 1'b1, 32'd1), 1, 0);
    chk("halt_add_refused", last_ir, 0);
    chk("halt_halted", halted, 1);
    chk("halt_count", count, 0);
    chk("halt_out_valid", out_valid, 0);
    step(1, rnd_ent(0), 1, 1);
    chk("halt_sticky_flush", halted, 1);
    chk("halt_in_ready", in_ready, 0);
    do_reset();

    // Asynchronous reset with two entries queued.
    step(1, rnd_ent(0), 0, 0);
    step(1, rnd_ent(0), 0, 0);
    chk("pre_rst_count", count, 2);
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (mst == 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, rnd_ent(1), 1'($urandom), $urandom_range(0, 19) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
